// File: rtl/bitwise_logic_unit_pkg.sv
// Shared op codes, FSM state encoding and counter sizing for bitwise_logic_unit.
// Pure declarations: no latency, no flow control of its own.
package bitwise_logic_unit_pkg;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } blu_state_e;

    // Slice counter width; a single-slice unit still keeps a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// Operand/result handshake bundle between the operand stage and the result mux.
// Optional zero flag present only with BITWISE_LOGIC_UNIT_ZERO_FLAG_EN.
interface bitwise_logic_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
`ifdef BITWISE_LOGIC_UNIT_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );
`endif
endinterface

// File: rtl/bitwise_logic_unit_logic_slice.sv
// SLICE-bit combinational AND/OR/XOR/NOR unit built from gate primitives.
// Zero latency, no flow control; the op code selects one of four gate outputs.
module logic_slice
    import bitwise_logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    logic [SLICE-1:0] y_and;
    logic [SLICE-1:0] y_or;
    logic [SLICE-1:0] y_xor;
    logic [SLICE-1:0] y_nor;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        and u_and (y_and[i], a[i], b[i]);
        or  u_or  (y_or[i],  a[i], b[i]);
        xor u_xor (y_xor[i], a[i], b[i]);
        nor u_nor (y_nor[i], a[i], b[i]);
    end

    always_comb begin
        y = y_nor;
        case (op)
            LOGIC_AND: y = y_and;
            LOGIC_OR:  y = y_or;
            LOGIC_XOR: y = y_xor;
            default:   y = y_nor;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Slice-serial WIDTH-bit AND/OR/XOR/NOR: result valid WIDTH/SLICE edges after accept,
// held until out_ready; no accept while busy or holding. Zero flag: BITWISE_LOGIC_UNIT_ZERO_FLAG_EN.
module bitwise_logic_unit
    import bitwise_logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    bitwise_logic_unit_if.slave bus
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = cnt_width(N);

    blu_state_e       state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] y_sl;
    logic             last_slice;

    // Counter-driven slice mux feeding the single shared logic slice.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < N; s++) begin
            if (idx_q == CW'(s)) begin
                a_sl = a_q[s*SLICE +: SLICE];
                b_sl = b_q[s*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .a  (a_sl),
        .b  (b_sl),
        .y  (y_sl)
    );

    assign last_slice = (idx_q == CW'(N - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int s = 0; s < N; s++) begin
                    if (idx_q == CW'(s)) begin
                        result_d[s*SLICE +: SLICE] = y_sl;
                    end
                end
                idx_d = idx_q + CW'(1);
                if (last_slice) begin
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are flopped from the next state so nothing is combinational to ports.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

`ifdef BITWISE_LOGIC_UNIT_ZERO_FLAG_EN
    logic acc_q, acc_d;
    logic zero_q, zero_d;

    // Running OR of written slices; the flag lands on the same edge as out_valid.
    always_comb begin
        acc_d  = acc_q;
        zero_d = zero_q;
        if (state_q == IDLE && bus.in_valid) begin
            acc_d = 1'b0;
        end else if (state_q == BUSY) begin
            acc_d = acc_q | (|y_sl);
            if (last_slice) begin
                zero_d = ~(acc_q | (|y_sl));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            acc_q  <= acc_d;
            zero_q <= zero_d;
        end
    end

    assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Randomised self-checking bench for bitwise_logic_unit (SLICE=8 and SLICE=32 instances).
module tb_bitwise_logic_unit;
    import bitwise_logic_unit_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bitwise_logic_unit_if #(.WIDTH(32)) bus8 ();
    bitwise_logic_unit_if #(.WIDTH(32)) bus32 ();

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus32.slave)
    );

    int passed = 0;
    int total  = 0;

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Stimulus only: issue one op on the SLICE=8 unit and wait for its result.
    task automatic run_op8(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res);
        int g;
        bus8.op = op;
        bus8.a = a;
        bus8.b = b;
        bus8.in_valid = 1'b1;
        g = 0;
        while (bus8.in_ready !== 1'b1 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        res = bus8.result;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus8.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); else passed++;
        total++; if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); else passed++;
        total++; if (bus8.result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus8.result); else passed++;
        total++; if (bus32.in_ready !== 1'b1) $display("FAIL reset_in_ready32: got %b want 1", bus32.in_ready); else passed++;
`ifdef BITWISE_LOGIC_UNIT_ZERO_FLAG_EN
        total++; if (bus8.zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", bus8.zero); else passed++;
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_spec_or();
        int lat;
        logic [31:0] res;
        run_op8(LOGIC_OR, 32'hF0F0_0000, 32'h0F0F_00FF, lat, res);
        total++; if (lat != 4) $display("FAIL or_latency: got %0d want 4", lat); else passed++;
        total++; if (res !== 32'hFFFF_00FF) $display("FAIL or_result: got %h want ffff00ff", res); else passed++;
        total++; if (bus8.in_ready !== 1'b0) $display("FAIL or_ready_in_done: got %b want 0", bus8.in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (bus8.out_valid !== 1'b0) $display("FAIL or_handoff_valid: got %b want 0", bus8.out_valid); else passed++;
        total++; if (bus8.in_ready !== 1'b1) $display("FAIL or_ready_after: got %b want 1", bus8.in_ready); else passed++;
    endtask

    task automatic test_ops();
        int lat;
        logic [31:0] res;
        logic [31:0] want;
        logic [1:0]  op;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin op = LOGIC_AND; want = 32'hFF00_0000; end
                1:       begin op = LOGIC_XOR; want = 32'h00FF_FF00; end
                default: begin op = LOGIC_NOR; want = 32'h0000_00FF; end
            endcase
            run_op8(op, 32'hFFFF_0000, 32'hFF00_FF00, lat, res);
            total++; if (res !== want || lat != 4) $display("FAIL op%0d: got %h lat %0d want %h lat 4", op, res, lat, want); else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        a = $urandom; b = $urandom; op = 2'($urandom_range(3));
        bus8.out_ready = 1'b0;
        run_op8(op, a, b, lat, res);
        total++; if (res !== ref_op(op, a, b)) $display("FAIL bp_result: got %h want %h", res, ref_op(op, a, b)); else passed++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus8.out_valid !== 1'b1 || bus8.result !== res || bus8.in_ready !== 1'b0)
                $display("FAIL bp_hold c%0d: valid %b result %h ready %b want 1 %h 0", c, bus8.out_valid, bus8.result, bus8.in_ready, res);
            else passed++;
        end
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus8.out_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", bus8.out_valid); else passed++;
    endtask

    task automatic test_busy_changes();
        logic [31:0] a0;
        logic [31:0] b0;
        int g;
        a0 = $urandom; b0 = $urandom;
        bus8.op = LOGIC_XOR; bus8.a = a0; bus8.b = b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        g = 0;
        while (bus8.out_valid !== 1'b1 && g < 50) begin
            total++; if (bus8.in_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", bus8.in_ready); else passed++;
            bus8.a = $urandom; bus8.b = $urandom; bus8.op = 2'($urandom_range(3));
            @(posedge clk); #1; g++;
        end
        bus8.in_valid = 1'b0;
        total++; if (g != 4) $display("FAIL busy_latency: got %0d want 4", g); else passed++;
        total++; if (bus8.result !== (a0 ^ b0)) $display("FAIL busy_captured: got %h want %h", bus8.result, a0 ^ b0); else passed++;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0)
                $display("FAIL busy_no_second c%0d: ready %b valid %b want 1 0", c, bus8.in_ready, bus8.out_valid);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        bus8.op = LOGIC_OR; bus8.a = 32'hFFFF_FFFF; bus8.b = 32'h0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        total++; if (bus8.out_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", bus8.out_valid); else passed++;
        total++; if (bus8.result !== 32'h0) $display("FAIL abort_result: got %h want 0", bus8.result); else passed++;
        total++; if (bus8.in_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", bus8.in_ready); else passed++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        run_op8(LOGIC_AND, a, b, lat, res);
        total++; if (res !== (a & b) || lat != 4) $display("FAIL abort_recover: got %h lat %0d want %h lat 4", res, lat, a & b); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat;
        int k;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        logic [1:0]  op;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                op = LOGIC_AND; a = 32'hAAAA_AAAA; b = 32'h5555_5555;
            end else begin
                op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
            end
            want = ref_op(op, a, b);
            k = int'($urandom_range(3));
            bus8.out_ready = (k == 0);
            run_op8(op, a, b, lat, res);
            total++; if (res !== want || lat != 4) $display("FAIL rand%0d: got %h lat %0d want %h lat 4", i, res, lat, want); else passed++;
`ifdef BITWISE_LOGIC_UNIT_ZERO_FLAG_EN
            total++; if (bus8.zero !== (want == 32'h0)) $display("FAIL rand_zero%0d: got %b want %b", i, bus8.zero, want == 32'h0); else passed++;
`endif
            for (int c = 0; c < k; c++) begin
                @(posedge clk); #1;
                total++; if (bus8.out_valid !== 1'b1 || bus8.result !== want) $display("FAIL rand_hold%0d: valid %b result %h want 1 %h", i, bus8.out_valid, bus8.result, want); else passed++;
            end
            bus8.out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_n1();
        int lat;
        int g;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        logic [1:0]  op;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                op = LOGIC_OR; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
            end else begin
                op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
            end
            want = ref_op(op, a, b);
            bus32.op = op; bus32.a = a; bus32.b = b; bus32.in_valid = 1'b1;
            g = 0;
            while (bus32.in_ready !== 1'b1 && g < 50) begin
                @(posedge clk); #1; g++;
            end
            @(posedge clk); #1;
            bus32.in_valid = 1'b0;
            lat = 0;
            while (bus32.out_valid !== 1'b1 && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            total++; if (lat != 1) $display("FAIL n1_latency%0d: got %0d want 1", i, lat); else passed++;
            total++; if (bus32.result !== want) $display("FAIL n1_result%0d: got %h want %h", i, bus32.result, want); else passed++;
`ifdef BITWISE_LOGIC_UNIT_ZERO_FLAG_EN
            total++; if (bus32.zero !== (want == 32'h0)) $display("FAIL n1_zero%0d: got %b want %b", i, bus32.zero, want == 32'h0); else passed++;
`endif
            @(posedge clk); #1;
            total++; if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) $display("FAIL n1_handoff%0d: ready %b valid %b want 1 0", i, bus32.in_ready, bus32.out_valid); else passed++;
        end
    endtask

    initial begin
        bus8.in_valid = 1'b0; bus8.op = 2'b00; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
        bus32.in_valid = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;
        test_reset();
        test_spec_or();
        test_ops();
        test_backpressure();
        test_busy_changes();
        test_reset_abort();
        test_random();
        test_n1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

- Parametrised, slice-serial successor to the fixed 32-bit OR operator.
- Computes AND, OR, XOR or NOR of two WIDTH-bit operands, SLICE bits per clock, and holds the result until consumed.
- Uses valid/ready handshakes on both sides and sits between the decode/operand stage and the result mux in the multi-cycle datapath.
- Trades per-operation latency for gate count on wide datapaths.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  unit can accept an operation.
- op  input  2  operation code: 00 AND, 01 OR, 10 XOR, 11 NOR.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0; present only with the macro (see Configuration).

## Operation
- N = WIDTH/SLICE. The slice counter has width max(1, clog2(N)).
- FSM states:
  - IDLE: in_ready=1. When in_valid is high, capture a, b and op into internal registers, clear the counter and go to BUSY.
  - BUSY: each cycle write result[idx*SLICE +: SLICE] = f(op, a_q slice, b_q slice) and increment idx. When idx == N-1, the write completes and the FSM goes to DONE.
  - DONE: out_valid=1. When out_ready is high, go to IDLE.
- Input signals are sampled only at acceptance. Later changes on a, b or op have no effect on the operation in flight.
- A result slice not yet written in the current operation keeps its value from the previous operation. result is valid only while out_valid=1.
- The unit does not accept an operation in the same cycle it hands a result off. in_ready rises the cycle after the handoff.
- in_valid is ignored outside IDLE; in_ready=0 there.
- Asserting reset_n low at any time aborts the operation in flight:
  - state goes to IDLE;
  - result, counter and captured operands clear to 0;
  - out_valid=0.
- Reset values: in_ready=1 (IDLE), out_valid=0, result=0, zero=1 (when the macro is defined).

## Timing
- An accept edge takes an operation. out_valid rises after N further rising edges.
  - Example: WIDTH=32, SLICE=8 gives out_valid high 4 cycles after the accept edge.
  - With SLICE=WIDTH, out_valid is high 1 cycle after the accept edge.
- Minimum issue interval is N+2 cycles: accept, N compute cycles, handoff.
- out_valid and result stay stable until the handoff edge. Backpressure of any length on out_ready is tolerated.
- in_ready, out_valid, result and zero are all registered, so no input feeds an output combinationally.

## Configuration
- The macro is BITWISE_LOGIC_UNIT_ZERO_FLAG_EN.
- When defined, the zero output port exists.
  - A running OR of the written slices sets zero in the same edge that sets out_valid.
  - zero is valid whenever out_valid=1.
- When undefined, the zero port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package:
  - 2-bit op encodings LOGIC_AND=2'b00, LOGIC_OR=2'b01, LOGIC_XOR=2'b10, LOGIC_NOR=2'b11;
  - FSM state encodings IDLE/BUSY/DONE.
- Sub-module logic_slice, parametrised by SLICE. It is a combinational SLICE-bit four-function unit built from gate primitives, instanced once and fed by a slice mux driven by the counter.

## Test plan
- Reset, then WIDTH=32, SLICE=8, op=01, a=32'hF0F0_0000, b=32'h0F0F_00FF, out_ready=1 → out_valid high 4 cycles after accept, result=32'hFFFF_00FF, then in_ready=1 the cycle after the handoff.
- Cover every op with a=32'hFFFF_0000, b=32'hFF00_FF00:
  - AND → 32'hFF00_0000;
  - XOR → 32'h00FF_FF00;
  - NOR → 32'h0000_00FF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. result and out_valid must be stable, and in_ready=0 throughout.
- Change a and b, and assert in_valid, during BUSY. The result must reflect the captured operands, and no second accept occurs.
- Assert reset_n low during the 2nd BUSY cycle. Immediately out_valid=0, result=0 and in_ready=1. A new operation after reset completes correctly.
- With the macro defined, op=00, a=32'hAAAA_AAAA, b=32'h5555_5555 → zero=1. Repeat with SLICE=32 (N=1) and op=01 → result=32'hFFFF_FFFF, zero=0, out_valid 1 cycle after accept.
